// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, default bit
// period and the parity helper. Used by the transmitter and the receiver.
package uart_pkg;

    // Serial frame states; PARITY_BIT is only entered in parity builds.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Default bit period, shared with the receiver.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Parity bit for a byte: even sense gives ^byte, odd sense gives ~^byte.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
//
// Handshake: a byte transfers on a rising clock edge where i_TX_DV and
// o_TX_Ready are both high. The producer holds i_TX_DV and i_TX_Byte
// stable until that edge; i_TX_DV while o_TX_Ready is low is ignored.
interface uart_tx_buffered_if;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       o_TX_Ready;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps. o_Tick marks the
// last cycle of a bit, o_Pre_Tick the cycle before it. i_Clear holds the
// count at zero. Reusable by the receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_Clear,
    output logic o_Tick,
    output logic o_Pre_Tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_Count;
    logic             w_Tick;

    assign w_Tick     = (r_Count == CNT_W'(CLKS_PER_BIT - 1));
    assign o_Tick     = w_Tick;
    assign o_Pre_Tick = (r_Count == CNT_W'(CLKS_PER_BIT - 2));

    // Count cycles within a bit, wrapping at the terminal count.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L || i_Clear) begin
            r_Count <= '0;
        end else if (w_Tick) begin
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-byte holding register so frames can run
// back-to-back. Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    uart_tx_buffered_if.slave        io_TX_If,
    output logic                     o_TX_Serial,
    output logic                     o_TX_Active,
    output logic                     o_TX_Done,
    output uart_state_t              o_Dbg_State
);

    uart_state_t r_State;
    logic        r_Serial;
    logic        r_Active;
    logic        r_Done;
    logic [7:0]  r_Shift;
    logic [2:0]  r_Bit_Idx;
    logic        r_Stop_Cnt;
    logic [7:0]  r_Hold_Byte;
    logic        r_Hold_Full;
`ifdef UART_TX_PARITY_EN
    logic        r_Parity;
`endif

    logic        w_Tick;
    logic        w_Pre_Tick;
    logic        w_Last_Stop;
    logic        w_Free;
    logic        w_Accept;
    logic        w_Load;
    logic [7:0]  w_Load_Byte;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock    (i_Clock),
        .i_Rst_L    (i_Rst_L),
        .i_Clear    (r_State == IDLE),
        .o_Tick     (w_Tick),
        .o_Pre_Tick (w_Pre_Tick)
    );

    // The shifter is free in IDLE or in the very last cycle of the final
    // stop bit, so a new frame can start on the following cycle.
    assign w_Last_Stop = (r_Stop_Cnt == 1'(STOP_BITS - 1));
    assign w_Free      = (r_State == IDLE) ||
                         ((r_State == STOP_BIT) && w_Tick && w_Last_Stop);
    assign w_Accept    = io_TX_If.i_TX_DV && !r_Hold_Full;
    // A held byte has priority; it cannot coincide with an accept since
    // Ready is low while the holding register is full.
    assign w_Load      = w_Free && (r_Hold_Full || io_TX_If.i_TX_DV);
    assign w_Load_Byte = r_Hold_Full ? r_Hold_Byte : io_TX_If.i_TX_Byte;

    assign io_TX_If.o_TX_Ready = ~r_Hold_Full;
    assign o_TX_Serial         = r_Serial;
    assign o_TX_Active         = r_Active;
    assign o_TX_Done           = r_Done;
    assign o_Dbg_State         = r_State;

    // Holding register: filled by an accept mid-frame, emptied when the
    // shifter takes the held byte.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_Hold_Full <= 1'b0;
            r_Hold_Byte <= '0;
        end else if (w_Free && r_Hold_Full) begin
            r_Hold_Full <= 1'b0;
        end else if (w_Accept && !w_Free) begin
            r_Hold_Full <= 1'b1;
            r_Hold_Byte <= io_TX_If.i_TX_Byte;
        end
    end

    // Frame FSM with registered line, active and done outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_State    <= IDLE;
            r_Serial   <= IDLE_LEVEL;
            r_Active   <= 1'b0;
            r_Done     <= 1'b0;
            r_Shift    <= '0;
            r_Bit_Idx  <= '0;
            r_Stop_Cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_Parity   <= 1'b0;
`endif
        end else begin
            // Done is registered, so it is set one cycle ahead of the last stop cycle.
            r_Done <= (r_State == STOP_BIT) && w_Last_Stop && w_Pre_Tick;
            if (w_Load) begin
                r_State    <= START_BIT;
                r_Serial   <= START_LEVEL;
                r_Active   <= 1'b1;
                r_Shift    <= w_Load_Byte;
                r_Bit_Idx  <= '0;
                r_Stop_Cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_Parity   <= parity_of(w_Load_Byte, PARITY_ODD);
`endif
            end else begin
                case (r_State)
                    IDLE: begin
                        r_Serial <= IDLE_LEVEL;
                        r_Active <= 1'b0;
                    end
                    START_BIT: begin
                        if (w_Tick) begin
                            r_State   <= DATA_BITS;
                            r_Serial  <= r_Shift[0];
                            r_Bit_Idx <= '0;
                        end
                    end
                    DATA_BITS: begin
                        if (w_Tick) begin
                            // Index wraps from 7 back to 0 on exit.
                            r_Bit_Idx <= r_Bit_Idx + 3'd1;
                            if (r_Bit_Idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                r_State  <= PARITY_BIT;
                                r_Serial <= r_Parity;
`else
                                r_State    <= STOP_BIT;
                                r_Serial   <= IDLE_LEVEL;
                                r_Stop_Cnt <= 1'b0;
`endif
                            end else begin
                                r_Shift  <= r_Shift >> 1;
                                r_Serial <= r_Shift[1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY_BIT: begin
                        if (w_Tick) begin
                            r_State    <= STOP_BIT;
                            r_Serial   <= IDLE_LEVEL;
                            r_Stop_Cnt <= 1'b0;
                        end
                    end
`endif
                    STOP_BIT: begin
                        if (w_Tick) begin
                            if (w_Last_Stop) begin
                                r_State    <= IDLE;
                                r_Serial   <= IDLE_LEVEL;
                                r_Active   <= 1'b0;
                                r_Stop_Cnt <= 1'b0;
                            end else begin
                                r_Stop_Cnt <= r_Stop_Cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_State  <= IDLE;
                        r_Serial <= IDLE_LEVEL;
                        r_Active <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef UART_TX_PARITY_EN
    // Without a parity bit the parity sense has no effect.
    if (PARITY_ODD) begin : g_parity_sense_ignored
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Two instances: u_dut1 (STOP_BITS=1, even
// parity) and u_dut2 (STOP_BITS=2, odd parity), CLKS_PER_BIT=4. Build with
// or without UART_TX_PARITY_EN.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LEN1 = (10 + PAR_BITS) * CPB;
    localparam int LEN2 = (11 + PAR_BITS) * CPB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    uart_tx_buffered_if if1 ();
    uart_tx_buffered_if if2 ();

    logic        ser1, act1, done1, ser2, act2, done2;
    uart_state_t st1, st2;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_dut1 (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .io_TX_If    (if1),
        .o_TX_Serial (ser1),
        .o_TX_Active (act1),
        .o_TX_Done   (done1),
        .o_Dbg_State (st1)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1'b1)) u_dut2 (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .io_TX_If    (if2),
        .o_TX_Serial (ser2),
        .o_TX_Active (act2),
        .o_TX_Done   (done2),
        .o_Dbg_State (st2)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         starts[$];
    int         ends[$];
    int         frames_seen = 0;
    int         checks      = 0;
    int         failures    = 0;
    logic       mon_en      = 1'b0;
    logic       mon_abort   = 1'b0;
    logic       mon_sel     = 1'b0;

    logic m_ser, m_act, m_done;
    assign m_ser  = mon_sel ? ser2  : ser1;
    assign m_act  = mon_sel ? act2  : act1;
    assign m_done = mon_sel ? done2 : done1;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endfunction

    // ---------------- monitor: pops expected bytes as frames appear ----------------
    initial begin : monitor
        logic [7:0] b;
        logic       bits [0:11];
        int         nbits;
        int         fstart;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_ser === 1'b0) begin
                    fstart = cyc;
                    check("frame_expected", exp_q.size() > 0, 1);
                    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    nbits = 0;
                    bits[nbits] = 1'b0;
                    nbits++;
                    for (int i = 0; i < 8; i++) begin
                        bits[nbits] = b[i];
                        nbits++;
                    end
`ifdef UART_TX_PARITY_EN
                    bits[nbits] = (^b) ^ mon_sel;
                    nbits++;
`endif
                    for (int s = 0; s < (mon_sel ? 2 : 1); s++) begin
                        bits[nbits] = 1'b1;
                        nbits++;
                    end
                    for (int bi = 0; bi < nbits; bi++) begin
                        for (int k = 0; k < CPB; k++) begin
                            if (bi != 0 || k != 0) @(negedge clk);
                            if (!mon_abort) begin
                                check("line_bit", m_ser, bits[bi]);
                                check("active_in_frame", m_act, 1);
                                check("done_pulse", m_done, (bi == nbits - 1) && (k == CPB - 1));
                            end
                        end
                    end
                    if (!mon_abort) begin
                        starts.push_back(fstart);
                        ends.push_back(cyc);
                        frames_seen++;
                    end
                end else if (!mon_abort) begin
                    check("idle_active", m_act, 0);
                    check("idle_done", m_done, 0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_if(input logic sel, input logic dv, input logic [7:0] b);
        if (sel) begin
            if2.i_TX_DV = dv;
            if2.i_TX_Byte = b;
        end else begin
            if1.i_TX_DV = dv;
            if1.i_TX_Byte = b;
        end
    endtask

    task automatic send(input logic sel, input logic [7:0] b, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        drive_if(sel, 1'b1, b);
        while ((sel ? if2.o_TX_Ready : if1.o_TX_Ready) !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", waited < 200, 1);
        acc_cyc = cyc;
        if (waited < 200) exp_q.push_back(b);
        @(posedge clk);
        #1;
        drive_if(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", frames_seen >= target, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int a0, a1, a2, base;
        logic saw_low, saw_done;

        rst_n = 1'b0;
        drive_if(1'b0, 1'b0, 8'h00);
        drive_if(1'b1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_serial1", ser1, 1);
        check("rst_active1", act1, 0);
        check("rst_done1", done1, 0);
        check("rst_ready1", if1.o_TX_Ready, 1);
        check("rst_state1", st1, IDLE);
        check("rst_serial2", ser2, 1);
        check("rst_ready2", if2.o_TX_Ready, 1);
        check("rst_state2", st2, IDLE);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0xA5: latency, length, done position.
        base = frames_seen;
        send(1'b0, 8'hA5, a0);
        wait_frames(base + 1, LEN1 + 20);
        if (frames_seen > base) begin
            check("t1_start_latency", starts[base] - a0, 1);
            check("t1_frame_len", ends[base] - starts[base] + 1, LEN1);
            check("t1_done_cycle", ends[base] - a0, LEN1);
        end
        repeat (5) @(negedge clk);

        // 0x00 then 0xFF five cycles later: held byte, no gap.
        base = frames_seen;
        send(1'b0, 8'h00, a1);
        while (cyc < a1 + 4) @(negedge clk);
        send(1'b0, 8'hFF, a2);
        @(negedge clk);
        check("t2_ready_low_c6", if1.o_TX_Ready, 0);
        while (cyc < a1 + LEN1) @(negedge clk);
        check("t2_ready_low_last_stop", if1.o_TX_Ready, 0);
        @(negedge clk);
        check("t2_ready_high_second_start", if1.o_TX_Ready, 1);
        wait_frames(base + 2, 2 * LEN1 + 20);
        if (frames_seen > base + 1) begin
            check("t2_no_gap", starts[base + 1], ends[base] + 1);
            check("t2_total_active", ends[base + 1] - starts[base] + 1, 2 * LEN1);
        end
        repeat (5) @(negedge clk);

        // DV held with a third byte while Ready is low: ignored.
        base = frames_seen;
        send(1'b0, 8'h11, a0);
        send(1'b0, 8'h22, a1);
        @(negedge clk);
        drive_if(1'b0, 1'b1, 8'h33);
        repeat (25) begin
            @(negedge clk);
            check("t3_ready_low_held", if1.o_TX_Ready, 0);
        end
        drive_if(1'b0, 1'b0, 8'h00);
        wait_frames(base + 2, 2 * LEN1 + 20);
        repeat (2 * LEN1) @(negedge clk);
        check("t3_frame_count", frames_seen, base + 2);
        check("t3_queue_empty", exp_q.size(), 0);

        // Reset during data bit 3 of 0x3C with 0x99 held.
        base = frames_seen;
        send(1'b0, 8'h3C, a0);
        send(1'b0, 8'h99, a1);
        while (cyc < a0 + 18) @(negedge clk);
        mon_abort = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_serial_after_rst", ser1, 1);
        check("t4_ready_after_rst", if1.o_TX_Ready, 1);
        check("t4_active_after_rst", act1, 0);
        check("t4_done_after_rst", done1, 0);
        check("t4_state_after_rst", st1, IDLE);
        rst_n = 1'b1;
        saw_low  = 1'b0;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ser1 !== 1'b1) saw_low = 1'b1;
            if (done1 !== 1'b0) saw_done = 1'b1;
        end
        check("t4_no_frame_resumes", saw_low, 0);
        check("t4_no_done_pulse", saw_done, 0);
        check("t4_frame_count", frames_seen, base);
        exp_q.delete();
        mon_abort = 1'b0;
        repeat (3) @(negedge clk);

        // 0x07 on the even-parity instance.
        base = frames_seen;
        send(1'b0, 8'h07, a0);
        wait_frames(base + 1, LEN1 + 20);
        if (frames_seen > base) check("t5_len_even", ends[base] - starts[base] + 1, LEN1);
        repeat (3) @(negedge clk);

        // Two stop bits, odd parity: 0x07 then 0x55 back-to-back.
        mon_sel = 1'b1;
        repeat (3) @(negedge clk);
        base = frames_seen;
        send(1'b1, 8'h07, a0);
        send(1'b1, 8'h55, a1);
        wait_frames(base + 2, 2 * LEN2 + 20);
        if (frames_seen > base + 1) begin
            check("t6_start_latency", starts[base] - a0, 1);
            check("t6_len_first", ends[base] - starts[base] + 1, LEN2);
            check("t6_no_gap", starts[base + 1], ends[base] + 1);
            check("t6_len_second", ends[base + 1] - starts[base + 1] + 1, LEN2);
        end
        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
